// File: rtl/semaforo_param.sv
// Traffic-light FSM with pedestrian request latch, all-red clearance and flashing-amber night mode.
// All lamps are registered (one cycle after the deciding edge); no backpressure, inputs are sampled every cycle.
module semaforo_param #(
  parameter int CNT_W       = 8,
  parameter int T_VERDE     = 50,
  parameter int T_MIN_VERDE = 10,
  parameter int T_AMARILLO  = 5,
  parameter int T_ROJO      = 20,
  parameter int T_DESPEJE   = 3,
  parameter int T_PARPADEO  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pulsador,
  input  logic modo_noche,
  output logic rojo,
  output logic amarillo,
  output logic verde,
  output logic blanco,
  output logic espera
);

  typedef enum logic [2:0] {
    DESPEJE,
    VERDE,
    AMARILLO,
    ROJO,
    NOCHE
  } state_t;

  localparam logic [CNT_W-1:0] VERDE_FIN    = CNT_W'(T_VERDE - 1);
  localparam logic [CNT_W-1:0] MIN_FIN      = CNT_W'(T_MIN_VERDE - 1);
  localparam logic [CNT_W-1:0] AMARILLO_FIN = CNT_W'(T_AMARILLO - 1);
  localparam logic [CNT_W-1:0] ROJO_FIN     = CNT_W'(T_ROJO - 1);
  localparam logic [CNT_W-1:0] DESPEJE_FIN  = CNT_W'(T_DESPEJE - 1);
  localparam logic [CNT_W-1:0] PARPADEO_FIN = CNT_W'(T_PARPADEO - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             s1, s2, s3;
  logic             req_edge;
  logic             entering;
  logic             rojo_d, amarillo_d, verde_d, blanco_d, espera_d;

  // s1/s2 resynchronise the button; s3 delays s2 so a held press yields one edge
  assign req_edge = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DESPEJE;
      cnt      <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      rojo     <= 1'b1;
      amarillo <= 1'b0;
      verde    <= 1'b0;
      blanco   <= 1'b0;
      espera   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      s1       <= pulsador;
      s2       <= s1;
      s3       <= s2;
      rojo     <= rojo_d;
      amarillo <= amarillo_d;
      verde    <= verde_d;
      blanco   <= blanco_d;
      espera   <= espera_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      DESPEJE: begin
        if (cnt == DESPEJE_FIN) state_d = modo_noche ? NOCHE : VERDE;
      end
      VERDE: begin
        if (modo_noche || (espera && (cnt >= MIN_FIN)) || (cnt == VERDE_FIN))
          state_d = AMARILLO;
      end
      AMARILLO: begin
        if (cnt == AMARILLO_FIN) state_d = modo_noche ? NOCHE : ROJO;
      end
      ROJO: begin
        if (cnt == ROJO_FIN) state_d = DESPEJE;
      end
      NOCHE: begin
        if (!modo_noche) state_d = DESPEJE;
      end
      default: state_d = DESPEJE;
    endcase
  end

  always_comb begin
    entering   = (state_d != state);
    cnt_d      = entering ? '0 : cnt + 1'b1;
    rojo_d     = (state_d == DESPEJE) || (state_d == ROJO);
    verde_d    = (state_d == VERDE);
    amarillo_d = (state_d == AMARILLO);
    blanco_d   = 1'b0;
    espera_d   = espera;

    // In night mode the counter wraps every half-period and the amber lamp itself holds the blink phase
    if (state_d == NOCHE) begin
      if (entering) begin
        amarillo_d = 1'b1;
      end else if (cnt == PARPADEO_FIN) begin
        cnt_d      = '0;
        amarillo_d = ~amarillo;
      end else begin
        amarillo_d = amarillo;
      end
    end

    // A request arriving on the very edge that enters red is still served in this red
    if (state_d == ROJO) blanco_d = entering ? (espera | req_edge) : blanco;

    if ((state_d == NOCHE) && entering) begin
      espera_d = 1'b0;
    end else if (state == NOCHE) begin
      espera_d = 1'b0;
    end else if ((state_d == ROJO) && entering) begin
      espera_d = 1'b0;
    end else if (req_edge && !((state == ROJO) && blanco)) begin
      espera_d = 1'b1;
    end
  end

endmodule

// File: doc/semaforo_param.md
Name: semaforo_param

Overview:
- Parametrised successor to the single-intersection traffic-light controller.
- Drives vehicle lights (rojo/amarillo/verde) and the pedestrian walk light (blanco) from one FSM with per-phase cycle counts.
- Adds pedestrian request latching with a minimum-green guarantee, an all-red clearance phase, and a night mode (flashing amber).
- Sits between the board push-button / mode switch and the lamp drivers.

Parameters:
- CNT_W, 8, phase counter width; every T_* must be ≤ 2^CNT_W.
- T_VERDE, 50, maximum green duration in cycles when no request is pending.
- T_MIN_VERDE, 10, minimum green before a request is honoured; 1 ≤ T_MIN_VERDE ≤ T_VERDE.
- T_AMARILLO, 5, amber duration in cycles.
- T_ROJO, 20, red duration in cycles; blanco is lit for this whole phase only when served.
- T_DESPEJE, 3, all-red clearance duration in cycles.
- T_PARPADEO, 4, night-mode amber half-period in cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- pulsador  in  1  pedestrian button; asynchronous to clk, level input.
- modo_noche  in  1  night-mode request; level input, synchronous to clk.
- rojo  out  1  vehicle red.
- amarillo  out  1  vehicle amber.
- verde  out  1  vehicle green.
- blanco  out  1  pedestrian walk.
- espera  out  1  pedestrian request pending (button acknowledge lamp).

Behaviour:
- All outputs are registered. Exactly one of rojo/amarillo/verde is high, except in NOCHE (rojo=verde=0, amarillo blinks).
- Reset (rst=1 at a clk edge):
  - state=DESPEJE, cnt=0, espera=0, synchroniser cleared.
  - Next outputs: rojo=1, amarillo=verde=blanco=0.
  - Reset mid-phase aborts that phase immediately.
- Button path:
  - pulsador passes through a 2-flop synchroniser plus a delay flop; req_edge = s2 & ~s3.
  - espera goes high on the edge after req_edge, i.e. 3 clk edges after pulsador is first sampled high.
  - A held button produces exactly one request.
  - espera is set by req_edge in VERDE, AMARILLO, DESPEJE, or ROJO with blanco=0.
  - req_edge is ignored in ROJO with blanco=1 and in NOCHE.
- Phase counter:
  - cnt clears on every state entry and increments each cycle.
  - A phase of length T occupies exactly T cycles (cnt = 0 .. T-1).
- State machine:
  - DESPEJE: rojo=1.
    - At cnt = T_DESPEJE-1: go to NOCHE if modo_noche=1, else VERDE.
  - VERDE: verde=1. Go to AMARILLO when any of:
    - modo_noche=1 (immediate, no minimum);
    - espera=1 and cnt ≥ T_MIN_VERDE-1;
    - cnt = T_VERDE-1.
  - AMARILLO: amarillo=1; always runs the full T_AMARILLO.
    - At the end: go to NOCHE if modo_noche=1, else ROJO.
  - ROJO: rojo=1.
    - On entry: if espera=1, then blanco=1 for the whole phase and espera is cleared in the same entry cycle; otherwise blanco=0.
    - At cnt = T_ROJO-1: go to DESPEJE. blanco drops together with the state change.
  - NOCHE:
    - amarillo starts at 1 and toggles every T_PARPADEO cycles; rojo=verde=blanco=0.
    - espera is cleared on entry.
    - When modo_noche=0 is sampled: go to DESPEJE; the blink phase is discarded.
- Simultaneous events:
  - req_edge in the cycle VERDE exits on T_VERDE: request latched, served in the following ROJO.
  - req_edge in the same cycle as ROJO entry: that request is served in that ROJO.
  - rst overrides everything.

Test Plan:
- Reset, no button, modo_noche=0 → rojo=1 for 3 cycles, verde 50, amarillo 5, rojo 20 with blanco=0, rojo 3, verde; espera stays 0 throughout.
- pulsador high at green cycle 2 and held 100 cycles → espera=1 within 3 cycles; green lasts exactly 10 cycles; amarillo 5; rojo+blanco 20; espera clears on ROJO entry; no second walk phase.
- pulsador pulse at green cycle 40 → green ends on the cycle espera is seen (≤ cycle 44 of green, never past 50); blanco=1 for the next 20 red cycles.
- Button during ROJO with blanco=1 → ignored, espera stays 0. Button during ROJO with blanco=0 → espera=1, served in the next cycle after min green.
- modo_noche=1 at green cycle 5 → amarillo solid 5 cycles, then toggles every 4 cycles; button ignored with espera=0. Drop modo_noche → rojo 3 cycles, then verde.
- rst pulse at ROJO cycle 7 with blanco=1 → next edge: rojo=1, blanco=0, espera=0; DESPEJE runs a full 3 cycles, then verde.
